// File: rtl/part_lram_if.sv
// Bus bundle for part_lram: address, write data, per-bit active-low write enables,
// control strobes and the registered read data / busy status.
interface part_lram_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned AW    = 5
);
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] we_n;
    logic             ce;
    logic             latch_n;
    logic             clr_req;
    logic [WIDTH-1:0] dout;
    logic             busy;

    modport master (
        output addr, din, we_n, ce, latch_n, clr_req,
        input  dout, busy
    );

    modport slave (
        input  addr, din, we_n, ce, latch_n, clr_req,
        output dout, busy
    );
endinterface

// File: rtl/part_lram.sv
// Small bit-writable RAM with registered, latchable read port and a self-clearing sweep.
// Define LRAM_WRITE_THROUGH_EN to make a same-address read return the merged new word.
module part_lram #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic       clk,
    input  logic       reset,
    part_lram_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    cnt_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             addr_ok;
    logic             wr_en;
    logic             dout_zero;
    logic [WIDTH-1:0] mem_word;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] dout_q;
    logic             busy_q;

    // Next-state and clear-address sequencing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Datapath: address range check, bit-merge of the write and the read word
    always_comb begin
        addr_ok   = ({1'b0, bus.addr} < DEPTH_X);
        wr_en     = (state == IDLE) && bus.ce && addr_ok;
        dout_zero = (state == CLEAR) || (state_next == CLEAR);
        mem_word  = addr_ok ? mem[bus.addr] : '0;
        merged    = (mem_word & bus.we_n) | (bus.din & ~bus.we_n);
`ifdef LRAM_WRITE_THROUGH_EN
        rd_word   = addr_ok ? merged : '0;
`else
        rd_word   = mem_word;
`endif
    end

    // Array storage has no reset; only the sweep zeros it
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_en) begin
            mem[bus.addr] <= merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
            dout_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy_q <= (state_next == CLEAR);
            // Output is forced low through the sweep, including its entry and exit edges
            if (dout_zero) begin
                dout_q <= '0;
            end else if (bus.latch_n) begin
                dout_q <= bus.ce ? rd_word : '0;
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_part_lram.sv
// Directed bench for part_lram: vector table for IDLE reads/writes plus hand sequences
// for reset sweep, clear requests, read-during-write and out-of-range addressing.
module tb_part_lram;
    localparam int unsigned WIDTH  = 2;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned DEPTH2 = 20;

`ifdef LRAM_WRITE_THROUGH_EN
    localparam logic [1:0] EXP_RW = 2'b10;
`else
    localparam logic [1:0] EXP_RW = 2'b01;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    part_lram_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
    part_lram_if #(.WIDTH(WIDTH), .AW(AW)) bus2 ();

    part_lram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    part_lram #(.WIDTH(WIDTH), .DEPTH(DEPTH2), .AW(AW)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    din;
        logic [1:0]    we_n;
        logic          ce;
        logic          latch_n;
        logic [1:0]    exp;
    } vec_t;

    vec_t vecs [14];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [1:0] d, input logic [1:0] w,
                         input logic c, input logic l, input logic clr);
        bus.addr    = a;
        bus.din     = d;
        bus.we_n    = w;
        bus.ce      = c;
        bus.latch_n = l;
        bus.clr_req = clr;
    endtask

    task automatic drive2(input logic [AW-1:0] a, input logic [1:0] d, input logic [1:0] w,
                          input logic c, input logic l);
        bus2.addr    = a;
        bus2.din     = d;
        bus2.we_n    = w;
        bus2.ce      = c;
        bus2.latch_n = l;
        bus2.clr_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic read_all_nonzero(output int nz);
        nz = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(AW'(a), 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
            step();
            if (bus.dout !== 2'b00) nz++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nz;

        // addr, din, we_n, ce, latch_n, expected dout after the edge
        vecs[0]  = '{5'd5,  2'b11, 2'b10, 1'b1, 1'b0, 2'b00};
        vecs[1]  = '{5'd5,  2'b00, 2'b11, 1'b1, 1'b1, 2'b01};
        vecs[2]  = '{5'd5,  2'b10, 2'b00, 1'b1, 1'b0, 2'b01};
        vecs[3]  = '{5'd9,  2'b11, 2'b11, 1'b0, 1'b0, 2'b01};
        vecs[4]  = '{5'd5,  2'b00, 2'b11, 1'b1, 1'b1, 2'b10};
        vecs[5]  = '{5'd5,  2'b00, 2'b11, 1'b0, 1'b1, 2'b00};
        vecs[6]  = '{5'd3,  2'b10, 2'b01, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{5'd3,  2'b01, 2'b10, 1'b1, 1'b0, 2'b00};
        vecs[8]  = '{5'd3,  2'b00, 2'b11, 1'b1, 1'b1, 2'b11};
        vecs[9]  = '{5'd31, 2'b11, 2'b00, 1'b1, 1'b0, 2'b11};
        vecs[10] = '{5'd31, 2'b00, 2'b11, 1'b1, 1'b1, 2'b11};
        vecs[11] = '{5'd0,  2'b00, 2'b11, 1'b1, 1'b1, 2'b00};
        vecs[12] = '{5'd3,  2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
        vecs[13] = '{5'd3,  2'b00, 2'b11, 1'b1, 1'b1, 2'b11};

        reset = 1'b0;
        drive(5'd0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
        drive2(5'd0, 2'b00, 2'b11, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_dout", 8'(bus.dout), 8'h00);
        check("reset_busy", 8'(bus.busy), 8'h01);

        // Power-up sweep length and cleared contents
        step();
        step();
        #3;
        reset = 1'b0;
        count_busy(n);
        check("reset_sweep_len", 8'(n), 8'd32);
        check("dut2_idle", 8'(bus2.busy), 8'h00);
        drive(5'd0, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        check("read_addr0", 8'(bus.dout), 8'h00);
        drive(5'd31, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        check("read_addr31", 8'(bus.dout), 8'h00);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].addr, vecs[i].din, vecs[i].we_n, vecs[i].ce, vecs[i].latch_n, 1'b0);
            step();
            check($sformatf("vec%0d_dout", i), 8'(bus.dout), 8'(vecs[i].exp));
            check($sformatf("vec%0d_busy", i), 8'(bus.busy), 8'h00);
        end

        // Read-during-write on addr 7
        drive(5'd7, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd7, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
        step();
        check("rdw_same_edge", 8'(bus.dout), 8'(EXP_RW));
        drive(5'd7, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        check("rdw_after", 8'(bus.dout), 8'h02);

        // Out-of-range address on the DEPTH=20 instance
        drive2(5'd25, 2'b11, 2'b00, 1'b1, 1'b1);
        step();
        check("oor_write_dout", 8'(bus2.dout), 8'h00);
        drive2(5'd25, 2'b00, 2'b11, 1'b1, 1'b1);
        step();
        check("oor_read", 8'(bus2.dout), 8'h00);
        nz = 0;
        for (int a = 0; a < int'(DEPTH2); a++) begin
            drive2(AW'(a), 2'b00, 2'b11, 1'b1, 1'b1);
            step();
            if (bus2.dout !== 2'b00) nz++;
        end
        check("oor_no_alias", 8'(nz), 8'h00);
        drive2(5'd19, 2'b11, 2'b00, 1'b1, 1'b0);
        step();
        drive2(5'd19, 2'b00, 2'b11, 1'b1, 1'b1);
        step();
        check("last_word_rw", 8'(bus2.dout), 8'h03);
        drive2(5'd0, 2'b00, 2'b11, 1'b0, 1'b1);

        // clr_req with a concurrent read of a non-zero word
        drive(5'd3, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1);
        step();
        check("clr_entry_busy", 8'(bus.busy), 8'h01);
        check("clr_entry_dout", 8'(bus.dout), 8'h00);
        drive(5'd3, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        check("clr_mid_dout", 8'(bus.dout), 8'h00);
        count_busy(n);
        check("clr_sweep_len", 8'(n), 8'd31);
        step();
        check("clr_cleared_addr3", 8'(bus.dout), 8'h00);

        // Fill, clear, re-request mid-sweep, then reset mid-sweep
        for (int a = 0; a < int'(DEPTH); a++) begin
            drive(AW'(a), 2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(5'd0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1);
        step();
        check("fill_clr_busy", 8'(bus.busy), 8'h01);
        drive(5'd0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step();
        drive(5'd0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1);
        step();
        drive(5'd0, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0);
        check("reclr_busy", 8'(bus.busy), 8'h01);
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        #1;
        check("midsweep_rst_busy", 8'(bus.busy), 8'h01);
        check("midsweep_rst_dout", 8'(bus.dout), 8'h00);
        step();
        step();
        #3;
        reset = 1'b0;
        count_busy(n);
        check("restart_sweep_len", 8'(n), 8'd32);
        read_all_nonzero(nz);
        check("all_words_zero", 8'(nz), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
